// File: rtl/row_wl_pkg.sv
// Shared types and helpers for the row wordline sequencer.
// Build option: ROW_WL_ACTIVE_LOW_EN selects active-low wordlines.
package row_wl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  // Wraps explicitly so non-power-of-two row counts stay in range.
  function automatic int next_row(
    input int   row,
    input int   rows,
    input logic dir
  );
    if (dir == DIR_DEC)
      return (row == 0) ? rows - 1 : row - 1;
    else
      return (row == rows - 1) ? 0 : row + 1;
  endfunction

endpackage

// File: rtl/row_onehot_dec.sv
// Enabled one-hot row decoder; addresses past the last row decode to zero.
// Build option: none (ROW_WL_ACTIVE_LOW_EN handled by the sequencer).
module row_onehot_dec #(
  parameter int ADDR_W = 4,
  parameter int ROWS   = 16
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROWS-1:0]   dec
);

  always_comb begin
    dec = '0;
    for (int i = 0; i < ROWS; i++)
      dec[i] = en && (32'(addr) == i);
  end

endmodule

// File: rtl/row_wl_sequencer.sv
// Registered wordline burst sequencer with wrap, abort and range error.
// Build option: ROW_WL_ACTIVE_LOW_EN inverts wl_out (idle all-ones).
module row_wl_sequencer
  import row_wl_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int ROWS      = 16,
  parameter int LEN_W     = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_dir,
  input  logic              abort,
  output logic [ROWS-1:0]   wl_out,
  output logic [ADDR_W-1:0] cur_row,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CMAX =
    (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW = $clog2(CMAX + 1);

`ifdef ROW_WL_ACTIVE_LOW_EN
  localparam logic [ROWS-1:0] WL_IDLE = {ROWS{1'b1}};
`else
  localparam logic [ROWS-1:0] WL_IDLE = '0;
`endif

  state_e            state, state_n;
  logic [ADDR_W-1:0] row_q, row_n, row_adv;
  logic [LEN_W-1:0]  rem_q, rem_n;
  logic              dir_q, dir_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              err_n;
  logic              pulse_end, gap_end, oor;
  logic [ROWS-1:0]   dec;

  assign row_adv   = ADDR_W'(next_row(32'(row_q), ROWS, dir_q));
  assign pulse_end = 32'(cnt_q) == PULSE_CYC - 1;
  assign gap_end   = 32'(cnt_q) == GAP_CYC - 1;
  assign oor       = 32'(req_addr) >= ROWS;

  always_comb begin
    state_n = state;
    row_n   = row_q;
    rem_n   = rem_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (oor) begin
            state_n = ST_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = ST_ASSERT;
            row_n   = req_addr;
            rem_n   = req_len;
            dir_n   = req_dir;
            cnt_n   = '0;
          end
        end
      end
      ST_ASSERT: begin
        if (abort) begin
          state_n = ST_DONE;
        end else if (pulse_end) begin
          cnt_n = '0;
          if (rem_q == '0) begin
            state_n = ST_DONE;
          end else if (GAP_CYC > 0) begin
            state_n = ST_GAP;
          end else begin
            row_n = row_adv;
            rem_n = rem_q - 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_n = ST_DONE;
        end else if (gap_end) begin
          state_n = ST_ASSERT;
          row_n   = row_adv;
          rem_n   = rem_q - 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  row_onehot_dec #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS)
  ) u_dec (
    .en   (state_n == ST_ASSERT),
    .addr (row_n),
    .dec  (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      row_q  <= '0;
      rem_q  <= '0;
      dir_q  <= DIR_INC;
      cnt_q  <= '0;
      err    <= 1'b0;
      wl_out <= WL_IDLE;
    end else begin
      state  <= state_n;
      row_q  <= row_n;
      rem_q  <= rem_n;
      dir_q  <= dir_n;
      cnt_q  <= cnt_n;
      err    <= err_n;
      wl_out <= dec ^ WL_IDLE;
    end
  end

  assign cur_row   = row_q;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_row_wl_sequencer.sv
// Directed bench: three sequencer instances (16 rows, 12 rows, no gap).
// Honours ROW_WL_ACTIVE_LOW_EN for expected wordline polarity.
module tb_row_wl_sequencer;

`ifdef ROW_WL_ACTIVE_LOW_EN
  localparam logic [31:0] INV = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] INV = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v0, d0, ab0, v1, d1, ab1, v2, d2, ab2;
  logic [3:0] a0, l0, a1, l1, a2, l2;
  logic       rdy0, rdy1, rdy2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       err0, err1, err2;
  logic [3:0] cr0, cr1, cr2;
  logic [15:0] wl0, wl2;
  logic [11:0] wl1;

  row_wl_sequencer u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
    .req_addr(a0), .req_len(l0), .req_dir(d0), .abort(ab0),
    .wl_out(wl0), .cur_row(cr0), .busy(busy0), .done(done0),
    .err(err0));

  row_wl_sequencer #(.ROWS(12)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
    .req_addr(a1), .req_len(l1), .req_dir(d1), .abort(ab1),
    .wl_out(wl1), .cur_row(cr1), .busy(busy1), .done(done1),
    .err(err1));

  row_wl_sequencer #(.GAP_CYC(0)) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
    .req_addr(a2), .req_len(l2), .req_dir(d2), .abort(ab2),
    .wl_out(wl2), .cur_row(cr2), .busy(busy2), .done(done2),
    .err(err2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int r, input int w);
    logic [31:0] m;
    m = (r < 0) ? 32'd0 : (32'd1 << r);
    return (m ^ INV) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic req(input int u, input int a,
                     input int n, input logic d);
    @(negedge clk);
    if (u == 0) begin
      v0 = 1'b1; a0 = 4'(a); l0 = 4'(n); d0 = d;
    end else if (u == 1) begin
      v1 = 1'b1; a1 = 4'(a); l1 = 4'(n); d1 = d;
    end else begin
      v2 = 1'b1; a2 = 4'(a); l2 = 4'(n); d2 = d;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    a0 = 4'hF; a1 = 4'hF; a2 = 4'hF;
    d0 = ~d0;  d1 = ~d1;  d2 = ~d2;
  endtask

  int seq2 [12] = '{14, 14, -1, 15, 15, -1, 0, 0, -1, 1, 1, -1};
  int seq3 [9]  = '{1, 1, -1, 0, 0, -1, 11, 11, -1};
  int seq7 [7]  = '{6, 6, 7, 7, 8, 8, -1};

  initial begin
    rst = 1'b1;
    {v0, d0, ab0, v1, d1, ab1, v2, d2, ab2} = '0;
    {a0, l0, a1, l1, a2, l2} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wl0", 32'(wl0), oh(-1, 16));
    chk("rst wl1", 32'(wl1), oh(-1, 12));
    chk("rst wl2", 32'(wl2), oh(-1, 16));
    chk("rst flags", {busy0, done0, err0, 28'(cr0)}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ready", {rdy0, rdy1, rdy2}, 32'h7);

    // single row
    req(0, 5, 0, 1'b0);
    @(negedge clk);
    chk("single c1 wl", 32'(wl0), oh(5, 16));
    chk("single c1 cur", 32'(cr0), 32'd5);
    chk("single c1 rdy", 32'(rdy0), 32'd0);
    chk("single c1 busy", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("single c2 wl", 32'(wl0), oh(5, 16));
    @(negedge clk);
    chk("single c3 wl", 32'(wl0), oh(-1, 16));
    chk("single c3 done", 32'(done0), 32'd1);
    chk("single c3 err", 32'(err0), 32'd0);
    @(negedge clk);
    chk("single c4 rdy", 32'(rdy0), 32'd1);
    chk("single c4 done", 32'(done0), 32'd0);

    // increment with wrap
    req(0, 14, 3, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("inc c%0d wl", k + 1), 32'(wl0), oh(seq2[k], 16));
      chk($sformatf("inc c%0d done", k + 1), 32'(done0), 32'(k == 11));
    end

    // decrement with wrap on 12 rows
    req(1, 1, 2, 1'b1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("dec c%0d wl", k + 1), 32'(wl1), oh(seq3[k], 12));
      chk($sformatf("dec c%0d done", k + 1), 32'(done1), 32'(k == 8));
      if (seq3[k] >= 0)
        chk($sformatf("dec c%0d cur", k + 1), 32'(cr1), 32'(seq3[k]));
    end

    // out of range on 12 rows
    @(negedge clk);
    req(1, 13, 0, 1'b0);
    @(negedge clk);
    chk("oor c1 wl", 32'(wl1), oh(-1, 12));
    chk("oor c1 done/err/busy", {done1, err1, busy1}, 32'h7);
    @(negedge clk);
    chk("oor c2 done/err/busy", {done1, err1, busy1}, 32'h0);
    chk("oor c2 wl", 32'(wl1), oh(-1, 12));

    // abort during the second row
    req(0, 3, 4, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort c4 wl", 32'(wl0), oh(4, 16));
    ab0 = 1'b1;
    @(negedge clk);
    ab0 = 1'b0;
    chk("abort c5 wl", 32'(wl0), oh(-1, 16));
    chk("abort c5 done", 32'(done0), 32'd1);
    @(negedge clk);
    chk("abort c6 rdy", 32'(rdy0), 32'd1);
    chk("abort c6 done", 32'(done0), 32'd0);

    // reset mid-burst
    req(0, 7, 3, 1'b0);
    repeat (2) @(negedge clk);
    chk("rstmid c2 wl", 32'(wl0), oh(7, 16));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid wl", 32'(wl0), oh(-1, 16));
    chk("rstmid flags", {busy0, done0, err0, 28'(cr0)}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid post%0d", k), {done0, busy0, rdy0}, 32'h1);
    end

    // back-to-back rows, no gap
    req(2, 6, 2, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("nogap c%0d wl", k + 1), 32'(wl2), oh(seq7[k], 16));
      chk($sformatf("nogap c%0d done", k + 1), 32'(done2), 32'(k == 6));
    end
    @(negedge clk);
    chk("nogap idle wl", 32'(wl2), oh(-1, 16));
    chk("nogap idle rdy", 32'(rdy2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
